// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the sync-pipe payload type
// for the frame-buffer address generator.
`timescale 1ns/1ps
package vga_timing_pkg;

  // Source image is 320x240; it is shown 2x upscaled on a 640x480 raster.
  localparam logic [9:0] SRC_W        = 10'd320;
  localparam logic [9:0] SRC_H        = 10'd240;

  localparam logic [9:0] H_ACTIVE     = 10'(2 * SRC_W);
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_TOTAL      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_SYNC_START + H_SYNC);

  localparam logic [9:0] V_ACTIVE     = 10'(2 * SRC_H);
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_TOTAL      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_SYNC_START + V_SYNC);

  // Everything that must trail the RAM read by RD_LAT cycles travels
  // together; the syncs are carried in their final polarity so the pipe
  // output can drive the pins straight from flops.
  typedef struct packed {
    logic active;
    logic hsync_n;
    logic vsync_n;
    logic vsync;
    logic frame_start;
  } sync_bus_t;

  localparam sync_bus_t SYNC_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                      vsync: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/sig_delay_pipe.sv
// Fixed-depth register pipe with an asynchronous active-low reset to a
// configurable idle value.
`timescale 1ns/1ps
module sig_delay_pipe #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the payload one stage per clock; reset flushes every stage to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= RESET_VAL;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_fb_addr_gen.sv
// VGA raster counters and 2x-upscaled frame-buffer address generator.
// Address and read strobe leave one cycle after the counters; the visible
// flag, syncs and frame marker trail them by RD_LAT more cycles so they
// line up with the data coming back from the RAM.
`timescale 1ns/1ps
module vga_fb_addr_gen
  import vga_timing_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rd_en,
  output logic [16:0] pixel_addr,
  output logic        active_area,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        vsync,
  output logic        frame_start
);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       vis_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic       fs_raw;
  sync_bus_t  sync_stage;
  sync_bus_t  sync_out;

  // Free-running raster position: h wraps every line, v advances on h wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 10'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Decode the current raster position into raw, un-delayed flags.
  always_comb begin
    vis_raw = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);
    hs_raw  = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    vs_raw  = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    fs_raw  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  end

  // Issue the read and capture the flags in the same cycle; dropping the
  // low counter bits repeats each source pixel on two columns and two lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en      <= 1'b0;
      pixel_addr <= '0;
      sync_stage <= SYNC_IDLE;
    end else begin
      rd_en      <= vis_raw;
      pixel_addr <= vis_raw ? {v_cnt[8:1], h_cnt[9:1]} : 17'd0;
      sync_stage <= '{active: vis_raw, hsync_n: ~hs_raw, vsync_n: ~vs_raw,
                      vsync: vs_raw, frame_start: fs_raw};
    end
  end

  sig_delay_pipe #(
    .WIDTH     ($bits(sync_bus_t)),
    .DEPTH     (RD_LAT),
    .RESET_VAL (SYNC_IDLE)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sync_stage),
    .dout  (sync_out)
  );

  assign active_area = sync_out.active;
  assign hsync_n     = sync_out.hsync_n;
  assign vsync_n     = sync_out.vsync_n;
  assign vsync       = sync_out.vsync;
  assign frame_start = sync_out.frame_start;

endmodule

// File: tb/tb_vga_fb_addr_gen.sv
// Bench for vga_fb_addr_gen: one instance at RD_LAT=1 and one at RD_LAT=3
// share clock and reset and are compared every cycle with an arithmetic
// raster model, plus a table of hand-computed checkpoints.
`timescale 1ns/1ps
module tb_vga_fb_addr_gen;

  localparam longint FRAME = 420000;

  typedef struct packed {
    logic        rd_en;
    logic [16:0] addr;
    logic        active;
    logic        hsync_n;
    logic        vsync_n;
    logic        vsync;
    logic        fs;
  } out_t;

  typedef struct {
    longint k;
    out_t   exp;
  } vec_t;

  logic clk;
  logic rst_n;

  logic        rd_en1, act1, hsn1, vsn1, vs1, fs1;
  logic [16:0] addr1;
  logic        rd_en3, act3, hsn3, vsn3, vs3, fs3;
  logic [16:0] addr3;

  int     tests;
  int     fails;
  longint k;

  int     mism1, mism3, pair_err;
  longint f1k, f3k;
  out_t   f1g, f1e, f3g, f3e;
  int     hs_run, vs_run, fs_count;
  longint last_fs_k;
  bit     fs_pending;

  vec_t   tbl[$];

  vga_fb_addr_gen #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en1), .pixel_addr(addr1),
    .active_area(act1), .hsync_n(hsn1), .vsync_n(vsn1), .vsync(vs1),
    .frame_start(fs1)
  );

  vga_fb_addr_gen #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en3), .pixel_addr(addr3),
    .active_area(act3), .hsync_n(hsn3), .vsync_n(vsn3), .vsync(vs3),
    .frame_start(fs3)
  );

  // 25 MHz pixel clock.
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  function automatic out_t mk(input bit rd, input int addr, input bit act,
                              input bit hsn, input bit vsn, input bit vs, input bit fs);
    out_t o;
    o.rd_en = rd; o.addr = 17'(addr); o.active = act;
    o.hsync_n = hsn; o.vsync_n = vsn; o.vsync = vs; o.fs = fs;
    return o;
  endfunction

  function automatic vec_t mv(input longint kk, input out_t e);
    vec_t v;
    v.k = kk; v.exp = e;
    return v;
  endfunction

  function automatic out_t pack1();
    return {rd_en1, addr1, act1, hsn1, vsn1, vs1, fs1};
  endfunction

  function automatic out_t pack3();
    return {rd_en3, addr3, act3, hsn3, vsn3, vs3, fs3};
  endfunction

  // Reference raster: after the k-th clock edge since reset release the
  // read stage shows raster slot k-1 and the aligned outputs show slot
  // k-1-lat; before a slot exists the outputs sit at their idle values.
  function automatic out_t model(input longint kk, input int lat);
    out_t   o;
    longint p;
    int     h, v;
    o = mk(0, 0, 0, 1, 1, 0, 0);
    if (kk >= 1) begin
      p = (kk - 1) % FRAME;
      h = int'(p % 800);
      v = int'(p / 800);
      if (h < 640 && v < 480) begin
        o.rd_en = 1'b1;
        o.addr  = 17'((v / 2) * 512 + h / 2);
      end
    end
    if (kk - 1 - lat >= 0) begin
      p = (kk - 1 - lat) % FRAME;
      h = int'(p % 800);
      v = int'(p / 800);
      o.active  = (h < 640 && v < 480);
      o.hsync_n = !(h >= 656 && h < 752);
      o.vsync   = (v == 490 || v == 491);
      o.vsync_n = !(v == 490 || v == 491);
      o.fs      = (p == 0);
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h (k=%0d)", name, actual, expected, k);
    end
  endtask

  task automatic clearTrackers();
    mism1 = 0; mism3 = 0; pair_err = 0;
    hs_run = 0; vs_run = 0; fs_count = 0;
    last_fs_k = -1; fs_pending = 1'b0;
  endtask

  // Advance n clock edges, comparing both instances with the model and
  // tracking sync pulse lengths and frame marker spacing.
  task automatic applyStimulus(input longint n);
    out_t o1, o3, e1, e3;
    for (longint i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      k++;
      o1 = pack1(); e1 = model(k, 1);
      o3 = pack3(); e3 = model(k, 3);
      if (o1 !== e1) begin
        if (mism1 == 0) begin f1k = k; f1g = o1; f1e = e1; end
        mism1++;
      end
      if (o3 !== e3) begin
        if (mism3 == 0) begin f3k = k; f3g = o3; f3e = e3; end
        mism3++;
      end
      if (vs1 === vsn1 || vs3 === vsn3) pair_err++;
      if (hsn1 === 1'b0) hs_run++;
      else if (hs_run > 0) begin
        checkOutput("hsync_low_len", hs_run, 96);
        hs_run = 0;
      end
      if (vsn1 === 1'b0) vs_run++;
      else if (vs_run > 0) begin
        checkOutput("vsync_low_len", vs_run, 1600);
        vs_run = 0;
      end
      if (fs_pending) begin
        checkOutput("frame_start_width", longint'(fs1), 0);
        fs_pending = 1'b0;
      end
      if (fs1 === 1'b1) begin
        fs_count++;
        if (last_fs_k >= 0) checkOutput("frame_start_interval", k - last_fs_k, FRAME);
        last_fs_k  = k;
        fs_pending = 1'b1;
      end
    end
  endtask

  task automatic runTo(input longint target);
    if (target > k) applyStimulus(target - k);
  endtask

  task automatic checkModel(input string name);
    checkOutput({name, "_model_lat1"}, mism1, 0);
    if (mism1 != 0) $display("[TB]   lat1 first divergence k=%0d got %h required %h", f1k, f1g, f1e);
    checkOutput({name, "_model_lat3"}, mism3, 0);
    if (mism3 != 0) $display("[TB]   lat3 first divergence k=%0d got %h required %h", f3k, f3g, f3e);
    checkOutput({name, "_vsync_pair"}, pair_err, 0);
    mism1 = 0; mism3 = 0; pair_err = 0;
  endtask

  task automatic checkIdle(input string name);
    checkOutput({name, "_lat1"}, longint'(pack1()), longint'(mk(0, 0, 0, 1, 1, 0, 0)));
    checkOutput({name, "_lat3"}, longint'(pack3()), longint'(mk(0, 0, 0, 1, 1, 0, 0)));
    checkOutput({name, "_counters"},
                longint'({u_lat1.h_cnt, u_lat1.v_cnt, u_lat3.h_cnt, u_lat3.v_cnt}), 0);
  endtask

  // Release reset mid low-phase so the next rising edge is edge 1.
  task automatic releaseReset(input int dly);
    @(negedge clk);
    #(dly);
    rst_n = 1'b1;
    k = 0;
    clearTrackers();
  endtask

  // Main sequence: table checkpoints over the first frame, three frame
  // markers, a mid-frame asynchronous reset, then random reset pulses.
  initial begin
    rst_n = 1'b0;
    k = 0;
    tests = 0;
    fails = 0;
    clearTrackers();

    tbl.push_back(mv(1,      mk(1, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(2,      mk(1, 0,      1, 1, 1, 0, 1)));
    tbl.push_back(mv(3,      mk(1, 1,      1, 1, 1, 0, 0)));
    tbl.push_back(mv(4,      mk(1, 1,      1, 1, 1, 0, 0)));
    tbl.push_back(mv(5,      mk(1, 2,      1, 1, 1, 0, 0)));
    tbl.push_back(mv(640,    mk(1, 319,    1, 1, 1, 0, 0)));
    tbl.push_back(mv(641,    mk(0, 0,      1, 1, 1, 0, 0)));
    tbl.push_back(mv(642,    mk(0, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(657,    mk(0, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(658,    mk(0, 0,      0, 0, 1, 0, 0)));
    tbl.push_back(mv(753,    mk(0, 0,      0, 0, 1, 0, 0)));
    tbl.push_back(mv(754,    mk(0, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(800,    mk(0, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(801,    mk(1, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(802,    mk(1, 0,      1, 1, 1, 0, 0)));
    tbl.push_back(mv(1601,   mk(1, 512,    0, 1, 1, 0, 0)));
    tbl.push_back(mv(1603,   mk(1, 513,    1, 1, 1, 0, 0)));
    tbl.push_back(mv(383840, mk(1, 122687, 1, 1, 1, 0, 0)));
    tbl.push_back(mv(383841, mk(0, 0,      1, 1, 1, 0, 0)));
    tbl.push_back(mv(392001, mk(0, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(392002, mk(0, 0,      0, 1, 0, 1, 0)));
    tbl.push_back(mv(393601, mk(0, 0,      0, 1, 0, 1, 0)));
    tbl.push_back(mv(393602, mk(0, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(420001, mk(1, 0,      0, 1, 1, 0, 0)));
    tbl.push_back(mv(420002, mk(1, 0,      1, 1, 1, 0, 1)));
    tbl.push_back(mv(420003, mk(1, 1,      1, 1, 1, 0, 0)));

    repeat (3) @(posedge clk);
    #1;
    checkIdle("reset_hold");
    releaseReset(5);
    checkOutput("release_no_edge", longint'(pack1()), longint'(mk(0, 0, 0, 1, 1, 0, 0)));

    for (int i = 0; i < tbl.size(); i++) begin
      runTo(tbl[i].k);
      checkOutput($sformatf("table_k%0d", tbl[i].k), longint'(pack1()), longint'(tbl[i].exp));
    end

    runTo(2 * FRAME + 3);
    checkModel("frames_1_3");
    checkOutput("frame_start_count", fs_count, 3);

    runTo(2 * FRAME + 1 + 200 * 800 + longint'($urandom_range(0, 799)));
    checkModel("frame3_to_line200");
    #6;
    rst_n = 1'b0;
    #1;
    checkIdle("async_reset_line200");
    repeat (2) @(posedge clk);
    #1;
    checkIdle("reset_held_line200");
    releaseReset(3);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("lat3_align_k%0d", i), longint'({rd_en3, act3, fs3}),
                  (i < 4) ? 3'b100 : ((i == 4) ? 3'b111 : 3'b110));
    end
    runTo(3000);
    checkModel("post_reset_lat3");

    for (int it = 0; it < 4; it++) begin
      applyStimulus(longint'($urandom_range(1, 5000)));
      checkModel($sformatf("rand%0d_run", it));
      #($urandom_range(2, 30));
      rst_n = 1'b0;
      #1;
      checkIdle($sformatf("rand%0d_async_reset", it));
      repeat ($urandom_range(1, 4)) @(posedge clk);
      releaseReset(int'($urandom_range(0, 15)));
      applyStimulus(longint'($urandom_range(100, 3000)));
      checkModel($sformatf("rand%0d_after_release", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
